// File: rtl/gcd_engine_pkg.sv
// gcd_engine_pkg
//    Shared definitions for the subtract-only GCD engine: FSM state
//    encodings, the default operand width and the cycle-counter width.
//    Optional feature macro: GCD_CYCLE_COUNT_EN (adds the saturating
//    subtraction counter and its increment helper).
package gcd_engine_pkg;

   localparam int GCD_WIDTH = 8;
   localparam int CYCLE_W   = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

`ifdef GCD_CYCLE_COUNT_EN
   // Counter sticks at all-ones instead of wrapping back to zero
   function automatic logic [CYCLE_W-1:0] satInc(input logic [CYCLE_W-1:0] v);
      return (v == {CYCLE_W{1'b1}}) ? v : v + 1'b1;
   endfunction
`endif

endpackage

// File: rtl/gcd_engine_if.sv
// gcd_engine_if
//    Start/ready/done handshake between the top-level sequencer (master)
//    and the GCD engine (slave).
//    Signals: start, a_in, b_in (master -> engine);
//             ready, done, result (engine -> master);
//             cycles (engine -> master, only with GCD_CYCLE_COUNT_EN).
interface gcd_engine_if import gcd_engine_pkg::*; #(
   parameter int WIDTH = GCD_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef GCD_CYCLE_COUNT_EN
   logic [CYCLE_W-1:0] cycles;

   modport master (output start, a_in, b_in, input ready, done, result, cycles);
   modport slave  (input start, a_in, b_in, output ready, done, result, cycles);
`else
   modport master (output start, a_in, b_in, input ready, done, result);
   modport slave  (input start, a_in, b_in, output ready, done, result);
`endif

endinterface

// File: rtl/gcd_engine_lt.sv
// gcd_engine_lt
//    Combinational unsigned less-than comparator that sits beside the GCD
//    engine at the top level.
//    Ports: x_i, y_i (operands), x_lt_y_o (1 when x_i < y_i).
module gcd_engine_lt import gcd_engine_pkg::*; #(
   parameter int WIDTH = GCD_WIDTH
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   output logic             x_lt_y_o
);

   assign x_lt_y_o = (x_i < y_i);

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine
//    Iterative subtract-only GCD of two unsigned operands. The engine keeps
//    X/Y in registers, hands them to an external less-than comparator and
//    uses its answer to decide which operand to reduce each cycle.
//    Ports: clk, rst (synchronous, active high);
//           bus    - gcd_engine_if slave (start/a_in/b_in in,
//                    ready/done/result out, cycles out when enabled);
//           x_q, y_q - current X/Y registers to the comparator;
//           x_lt_y - comparator answer for (x_q < y_q), same cycle.
//    Optional feature macro: GCD_CYCLE_COUNT_EN (subtraction count of the
//    last run on bus.cycles).
module gcd_engine import gcd_engine_pkg::*; #(
   parameter int WIDTH = GCD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   gcd_engine_if.slave      bus,
   output logic [WIDTH-1:0] x_q,
   output logic [WIDTH-1:0] y_q,
   input  logic             x_lt_y
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] x_d, y_d;
   logic [WIDTH-1:0] result_q, result_d;
`ifdef GCD_CYCLE_COUNT_EN
   logic [CYCLE_W-1:0] cnt_q, cnt_d;
   logic [CYCLE_W-1:0] cycles_q, cycles_d;
`endif

   // IDLE and DONE both accept a new request, which gives back-to-back
   // runs without an idle gap; only CALC blocks the handshake.
   assign bus.ready  = (state_q != ST_CALC);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.result = result_q;
`ifdef GCD_CYCLE_COUNT_EN
   assign bus.cycles = cycles_q;
`endif

   // Next-state logic. Equality is checked locally so the comparator only
   // has to decide direction; the smaller operand is always subtracted
   // from the larger one, so the subtraction never underflows. A zero
   // operand short-circuits straight to DONE with gcd = a | b.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_d    = cnt_q;
      cycles_d = cycles_q;
`endif
      if (state_q == ST_CALC) begin
         if (x_q == y_q) begin
            result_d = x_q;
            state_d  = ST_DONE;
`ifdef GCD_CYCLE_COUNT_EN
            cycles_d = cnt_q;
`endif
         end else begin
            if (x_lt_y) begin
               y_d = y_q - x_q;
            end else begin
               x_d = x_q - y_q;
            end
`ifdef GCD_CYCLE_COUNT_EN
            cnt_d = satInc(cnt_q);
`endif
         end
      end else if (bus.start) begin
         x_d = bus.a_in;
         y_d = bus.b_in;
`ifdef GCD_CYCLE_COUNT_EN
         cnt_d = '0;
`endif
         if ((bus.a_in == '0) || (bus.b_in == '0)) begin
            result_d = bus.a_in | bus.b_in;
            state_d  = ST_DONE;
`ifdef GCD_CYCLE_COUNT_EN
            cycles_d = '0;
`endif
         end else begin
            state_d = ST_CALC;
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

   // State registers; reset abandons any run in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
`ifdef GCD_CYCLE_COUNT_EN
         cnt_q    <= '0;
         cycles_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
`ifdef GCD_CYCLE_COUNT_EN
         cnt_q    <= cnt_d;
         cycles_q <= cycles_d;
`endif
      end
   end

endmodule
